slave_regfile: RTL and testbench
================================

SLAVE_REGFILE -- requirements
Module: slave_regfile

Interface
REQ-001 The block SHALL have parameter WAIT_MAX, default 3, giving the largest legal wait_cycles value.
REQ-002 Port clk  input  1  is the single rising-edge clock.
REQ-003 Port rst_n  input  1  is the reset: synchronous and active-low; one clock.
REQ-004 Port valid  input  1  is the request valid from the interconnect.
REQ-005 Port addr_in  input  3  is the register address; it is held with valid.
REQ-006 Port value_in  input  3  is the write data; it is held with valid.
REQ-007 Port wait_cycles  input  2  sets the number of wait states before ready; it is sampled on acceptance.
REQ-008 Port ready  output  1  is the slave ready; it is a registered output.
REQ-009 Port hs_pulse  output  1  is a registered one-cycle pulse, high the cycle after a handshake.
REQ-010 Port rd_addr  input  3  is the read-back address.
REQ-011 Port rd_data  output  3  is the read-back data: mem[rd_addr], registered, 1-cycle latency.
REQ-012 Port wr_count  output  8  is the count of completed handshakes; it wraps at 255 to 0.
REQ-013 Port err  output  1  is a sticky protocol-error flag.

Function
REQ-014 The FSM SHALL have the states IDLE, WAIT and RDY; ready SHALL equal (state==RDY).
REQ-015 IDLE: when valid=1, the FSM SHALL latch min(wait_cycles,WAIT_MAX) into cnt, addr_in into a_q and value_in into v_q, then go to RDY if the latched value is 0, else to WAIT.
REQ-016 WAIT: cnt SHALL decrement each cycle; the FSM SHALL go to RDY on the cycle cnt==1.
REQ-017 The handshake SHALL be valid && ready, sampled in the same cycle.
REQ-018 On a handshake, the block SHALL write mem[a_q] <= v_q, increment wr_count, set hs_pulse next cycle, and return to IDLE.
REQ-019 In RDY with valid=0, the FSM SHALL remain in RDY; ready SHALL hold high until the handshake.
REQ-020 From wait_cycles=N at acceptance, the first ready-high cycle SHALL come N+1 cycles after the acceptance edge.
REQ-021 Back-to-back requests: after a handshake, the block SHALL NOT re-accept before the IDLE cycle, so there is a minimum 1 idle cycle.
REQ-022 Address 0..7 SHALL all be writable; there is no wrap logic.
REQ-023 rd_data SHALL read pre-write data when rd_addr equals the address being written in that cycle (no bypass).

Reset
REQ-024 On an rst_n=0 clock edge: state=IDLE, ready=0, hs_pulse=0, rd_data=0, wr_count=0, err=0, cnt=0, and all 8 mem entries=0.
REQ-025 Reset asserted mid-transaction (WAIT or RDY) SHALL abort it with no mem write and no wr_count change.

Configuration
REQ-026 With macro SLAVE_REGFILE_ERR_CHK_EN defined: in WAIT, valid=0 or an addr_in/value_in change versus a_q/v_q SHALL set err=1 and return to IDLE with no write. err stays 1 until reset.
REQ-027 Without SLAVE_REGFILE_ERR_CHK_EN: err SHALL be tied to 0, and WAIT SHALL ignore valid/data changes and proceed to RDY.

Structure
REQ-028 A shared package slave_pkg SHALL hold the state enum (IDLE/WAIT/RDY), ADDR_W=3, DATA_W=3 and CNT_W=2.
REQ-029 The single sub-module slave_wait_ctr SHALL implement the load/decrement counter with a done flag; the rest stays in the top.

Verification
REQ-030 wait_cycles=0, valid with addr=5, value=6 -> ready high 1 cycle after acceptance; mem[5]=6; hs_pulse 1 cycle; wr_count=1.
REQ-031 wait_cycles=3, valid with addr=2, value=1 -> ready first high 4 cycles after acceptance; rd_addr=2 gives rd_data=1 one cycle later.
REQ-032 Eight sequential writes to addr 0..7 with value = addr^3 -> read-back matches every entry; wr_count=8.
REQ-033 Under SLAVE_REGFILE_ERR_CHK_EN: wait_cycles=2, drop valid during WAIT -> err=1, no write, ready never asserts, FSM in IDLE.
REQ-034 Reset asserted in RDY with valid=1 -> next cycle ready=0, mem all 0, wr_count=0.
REQ-035 wr_count preloaded by 255 handshakes, then one more -> wr_count=0.

Source files
------------

// File: rtl/slave_pkg.sv
// rtl/slave_pkg.sv - shared types, widths and helpers for the slave register file
package slave_pkg;

   localparam int ADDR_W    = 3;
   localparam int DATA_W    = 3;
   localparam int CNT_W     = 2;
   localparam int MEM_DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RDY  = 2'd2
   } state_e;

   // Limit a requested wait count to the configured maximum.
   function automatic logic [CNT_W-1:0] clamp_wait(input logic [CNT_W-1:0] w,
                                                   input int unsigned       max_w);
      logic [CNT_W-1:0] r;
      if (32'(w) > max_w) begin
         r = max_w[CNT_W-1:0];
      end else begin
         r = w;
      end
      return r;
   endfunction

endpackage

// File: rtl/slave_wait_ctr.sv
// rtl/slave_wait_ctr.sv - loadable down-counter producing the wait-state done flag
module slave_wait_ctr
   import slave_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: load wins over decrement; decrement saturates at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The last wait state is the one where the count reads 1.
   assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/slave_regfile.sv
// rtl/slave_regfile.sv - 8-entry register file slave with wait states; optional SLAVE_REGFILE_ERR_CHK_EN
module slave_regfile
   import slave_pkg::*;
#(
   parameter int unsigned WAIT_MAX = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] value_in,
   input  logic [CNT_W-1:0]  wait_cycles,
   output logic              ready,
   output logic              hs_pulse,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic [7:0]        wr_count,
   output logic              err
);

   state_e            state_q;
   state_e            state_d;
   logic [ADDR_W-1:0] a_q;
   logic [DATA_W-1:0] v_q;
   logic [DATA_W-1:0] mem_q [MEM_DEPTH];
   logic [DATA_W-1:0] rd_data_q;
   logic [7:0]        wr_count_q;
   logic              ready_q;
   logic              ready_d;
   logic              hs_pulse_q;
   logic              hs_pulse_d;
   logic              accept;
   logic              handshake;
   logic              in_wait;
   logic              wait_abort;
   logic              ctr_done;
   logic [CNT_W-1:0]  wait_val;

   assign in_wait   = (state_q == WAIT);
   assign accept    = (state_q == IDLE) && valid;
   assign handshake = (state_q == RDY) && valid;
   assign wait_val  = clamp_wait(wait_cycles, WAIT_MAX);

   slave_wait_ctr u_wait_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept),
      .load_val (wait_val),
      .dec      (in_wait),
      .done     (ctr_done)
   );

`ifdef SLAVE_REGFILE_ERR_CHK_EN
   logic err_q;

   // The request must stay valid and stable while waiting; anything else aborts it.
   assign wait_abort = in_wait && (!valid || (addr_in != a_q) || (value_in != v_q));

   // Sticky protocol error flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (wait_abort) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign wait_abort = 1'b0;
   assign err        = 1'b0;
`endif

   // State register together with the registered status outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ready_q    <= 1'b0;
         hs_pulse_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         hs_pulse_q <= hs_pulse_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (valid) begin
               state_d = (wait_val == '0) ? RDY : WAIT;
            end
         end
         WAIT: begin
            if (wait_abort) begin
               state_d = IDLE;
            end else if (ctr_done) begin
               state_d = RDY;
            end
         end
         RDY: begin
            if (valid) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic: ready mirrors the upcoming state so it is high exactly while in RDY.
   always_comb begin
      ready_d    = (state_d == RDY);
      hs_pulse_d = handshake;
   end

   // Request capture, register file write, read port and handshake counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q        <= '0;
         v_q        <= '0;
         rd_data_q  <= '0;
         wr_count_q <= '0;
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (accept) begin
            a_q <= addr_in;
            v_q <= value_in;
         end
         if (handshake) begin
            mem_q[a_q] <= v_q;
            wr_count_q <= wr_count_q + 8'd1;
         end
         rd_data_q <= mem_q[rd_addr];
      end
   end

   assign ready    = ready_q;
   assign hs_pulse = hs_pulse_q;
   assign rd_data  = rd_data_q;
   assign wr_count = wr_count_q;

endmodule

// File: tb/tb_slave_regfile.sv
// tb/tb_slave_regfile.sv - randomized self-checking bench for slave_regfile
module tb_slave_regfile;

   localparam int WAIT_MAX = 3;

   logic       clk;
   logic       rst_n;
   logic       valid;
   logic [2:0] addr_in;
   logic [2:0] value_in;
   logic [1:0] wait_cycles;
   logic       ready;
   logic       hs_pulse;
   logic [2:0] rd_addr;
   logic [2:0] rd_data;
   logic [7:0] wr_count;
   logic       err;

   int         n_checks;
   int         n_fail;

   // Reference state: register contents, handshake total, error flag.
   int         mem_model [8];
   int         wr_model;
   int         err_model;

   slave_regfile #(.WAIT_MAX(WAIT_MAX)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid       (valid),
      .addr_in     (addr_in),
      .value_in    (value_in),
      .wait_cycles (wait_cycles),
      .ready       (ready),
      .hs_pulse    (hs_pulse),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .wr_count    (wr_count),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_clear();
      for (int i = 0; i < 8; i++) mem_model[i] = 0;
      wr_model  = 0;
      err_model = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
   endtask

   // Read one entry and compare it against the model.
   task automatic read_check(input logic [2:0] a);
      rd_addr = a;
      @(negedge clk);
      n_checks++;
      if (rd_data !== 3'(mem_model[a])) begin
         n_fail++;
         $display("FAIL read addr=%0d got=%0d exp=%0d", a, rd_data, mem_model[a]);
      end
   endtask

   // One complete write transaction; hold = cycles valid is dropped while ready is up.
   task automatic do_write(input logic [2:0] a, input logic [2:0] v,
                           input logic [1:0] wc, input int hold);
      int lat;
      int exp_lat;
      int old;
      exp_lat = (int'(wc) > WAIT_MAX) ? WAIT_MAX : int'(wc);
      valid       = 1'b1;
      addr_in     = a;
      value_in    = v;
      wait_cycles = wc;
      @(posedge clk);
      @(negedge clk);
      wait_cycles = 2'($urandom);
      lat = 0;
      while (ready !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      n_checks++;
      if (ready !== 1'b1 || lat != exp_lat) begin
         n_fail++;
         $display("FAIL ready_latency wc=%0d got=%0d exp=%0d ready=%b", wc, lat, exp_lat, ready);
      end
      if (hold > 0) begin
         valid = 1'b0;
         repeat (hold) @(negedge clk);
         n_checks++;
         if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_hold got=%b exp=1", ready);
         end
         valid = 1'b1;
      end
      rd_addr = a;
      old = mem_model[a];
      @(negedge clk);
      n_checks++;
      if (hs_pulse !== 1'b1 || ready !== 1'b0 || rd_data !== 3'(old)) begin
         n_fail++;
         $display("FAIL handshake hs=%b ready=%b rd=%0d exp hs=1 ready=0 rd=%0d", hs_pulse, ready, rd_data, old);
      end
      mem_model[a] = int'(v);
      wr_model = (wr_model + 1) % 256;
      valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (hs_pulse !== 1'b0 || wr_count !== 8'(wr_model) || rd_data !== v) begin
         n_fail++;
         $display("FAIL post_write hs=%b cnt=%0d rd=%0d exp hs=0 cnt=%0d rd=%0d", hs_pulse, wr_count, rd_data, wr_model, v);
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (ready !== 1'b0 || hs_pulse !== 1'b0 || wr_count !== 8'd0 || err !== 1'b0 || rd_data !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_outputs ready=%b hs=%b cnt=%0d err=%b rd=%0d exp all 0", ready, hs_pulse, wr_count, err, rd_data);
      end
      for (int i = 0; i < 8; i++) read_check(3'(i));
   endtask

   task automatic test_zero_wait();
      do_write(3'd5, 3'd6, 2'd0, 0);
      read_check(3'd5);
      n_checks++;
      if (wr_count !== 8'd1) begin
         n_fail++;
         $display("FAIL zero_wait_count got=%0d exp=1", wr_count);
      end
   endtask

   task automatic test_wait3();
      do_write(3'd2, 3'd1, 2'd3, 0);
      read_check(3'd2);
   endtask

   task automatic test_sequential();
      do_reset();
      for (int i = 0; i < 8; i++) do_write(3'(i), 3'(i ^ 3), 2'($urandom_range(0, 3)), 0);
      for (int i = 0; i < 8; i++) read_check(3'(i));
      n_checks++;
      if (wr_count !== 8'd8) begin
         n_fail++;
         $display("FAIL seq_count got=%0d exp=8", wr_count);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 24; n++) begin
         do_write(3'($urandom), 3'($urandom), 2'($urandom), int'($urandom_range(0, 2)));
         read_check(3'($urandom));
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] a2;
      logic [2:0] v2;
      a2 = 3'($urandom);
      v2 = 3'($urandom);
      valid = 1'b1; addr_in = 3'd4; value_in = 3'd3; wait_cycles = 2'd0;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_first_ready got=%b exp=1", ready);
      end
      addr_in = a2; value_in = v2;
      @(negedge clk);
      mem_model[4] = 3;
      wr_model = (wr_model + 1) % 256;
      n_checks++;
      if (ready !== 1'b0 || hs_pulse !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_idle_gap ready=%b hs=%b exp ready=0 hs=1", ready, hs_pulse);
      end
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b1 || hs_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_reaccept ready=%b hs=%b exp ready=1 hs=0", ready, hs_pulse);
      end
      @(negedge clk);
      mem_model[a2] = int'(v2);
      wr_model = (wr_model + 1) % 256;
      valid = 1'b0;
      n_checks++;
      if (hs_pulse !== 1'b1 || wr_count !== 8'(wr_model)) begin
         n_fail++;
         $display("FAIL b2b_second hs=%b cnt=%0d exp hs=1 cnt=%0d", hs_pulse, wr_count, wr_model);
      end
      @(negedge clk);
      read_check(3'd4);
      read_check(a2);
   endtask

   task automatic test_reset_mid();
      int lat;
      valid = 1'b1; addr_in = 3'd7; value_in = 3'd5; wait_cycles = 2'd1;
      @(posedge clk);
      @(negedge clk);
      lat = 0;
      while (ready !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      valid = 1'b0;
      model_clear();
      n_checks++;
      if (ready !== 1'b0 || wr_count !== 8'd0 || hs_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_in_rdy ready=%b cnt=%0d hs=%b exp 0/0/0", ready, wr_count, hs_pulse);
      end
      for (int i = 0; i < 8; i++) read_check(3'(i));
      do_write(3'd1, 3'd2, 2'd0, 0);
      valid = 1'b1; addr_in = 3'd1; value_in = 3'd7; wait_cycles = 2'd3;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      valid = 1'b0;
      model_clear();
      repeat (5) @(negedge clk);
      n_checks++;
      if (ready !== 1'b0 || wr_count !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_in_wait ready=%b cnt=%0d exp 0/0", ready, wr_count);
      end
      read_check(3'd1);
   endtask

   task automatic test_wrap();
      do_reset();
      for (int n = 0; n < 255; n++) do_write(3'($urandom), 3'($urandom), 2'd0, 0);
      n_checks++;
      if (wr_count !== 8'd255) begin
         n_fail++;
         $display("FAIL wrap_preload got=%0d exp=255", wr_count);
      end
      do_write(3'($urandom), 3'($urandom), 2'd0, 0);
      n_checks++;
      if (wr_count !== 8'd0) begin
         n_fail++;
         $display("FAIL wrap_to_zero got=%0d exp=0", wr_count);
      end
   endtask

`ifdef SLAVE_REGFILE_ERR_CHK_EN
   task automatic test_err_check();
      int saw_ready;
      do_reset();
      valid = 1'b1; addr_in = 3'd3; value_in = 3'd4; wait_cycles = 2'd2;
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
      saw_ready = 0;
      repeat (6) begin
         @(negedge clk);
         if (ready === 1'b1) saw_ready = 1;
      end
      err_model = 1;
      n_checks++;
      if (saw_ready != 0 || err !== 1'b1 || wr_count !== 8'd0 || hs_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL err_abort ready_seen=%0d err=%b cnt=%0d exp 0/1/0", saw_ready, err, wr_count);
      end
      read_check(3'd3);
      do_write(3'd6, 3'd5, 2'd1, 0);
      n_checks++;
      if (err !== 1'(err_model)) begin
         n_fail++;
         $display("FAIL err_sticky got=%b exp=%0d", err, err_model);
      end
   endtask
`else
   task automatic test_wait_ignore();
      int lat;
      valid = 1'b1; addr_in = 3'd6; value_in = 3'd2; wait_cycles = 2'd3;
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0; addr_in = 3'd1; value_in = 3'd5;
      lat = 0;
      while (ready !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      n_checks++;
      if (ready !== 1'b1 || lat != 3 || err !== 1'(err_model)) begin
         n_fail++;
         $display("FAIL wait_ignore ready=%b lat=%0d err=%b exp 1/3/%0d", ready, lat, err, err_model);
      end
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      mem_model[6] = 2;
      wr_model = (wr_model + 1) % 256;
      n_checks++;
      if (hs_pulse !== 1'b1) begin
         n_fail++;
         $display("FAIL wait_ignore_hs got=%b exp=1", hs_pulse);
      end
      @(negedge clk);
      read_check(3'd6);
      read_check(3'd1);
   endtask
`endif

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      valid       = 1'b0;
      addr_in     = '0;
      value_in    = '0;
      wait_cycles = '0;
      rd_addr     = '0;
      model_clear();
      test_reset();
      test_zero_wait();
      test_wait3();
      test_sequential();
      test_random();
      test_back_to_back();
`ifdef SLAVE_REGFILE_ERR_CHK_EN
      test_err_check();
`else
      test_wait_ignore();
`endif
      test_reset_mid();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
